// File: rtl/step_dir_out.sv
// Purpose: turns 1-cycle pls strobes plus a dir level into driver-legal STEP/DIR pins with DIR setup and min widths.
// Latency: same dir -> STEP rises 1 enabled cycle after pls; dir change -> DIR moves after 1, STEP after 1+DIR_SETUP.
// Backpressure: none upstream; one pending pulse is buffered, further pls while it is full are dropped and flagged in overrun.
module step_dir_out #(
    parameter int STEP_HIGH = 4,
    parameter int STEP_LOW  = 4,
    parameter int DIR_SETUP = 3,
    parameter bit INV_STEP  = 1'b0,
    parameter bit INV_DIR   = 1'b0
) (
    input  logic               clk,
    input  logic               sclr_n,
    input  logic               clk_ena,
    input  logic               pls,
    input  logic               dir,
    input  logic               abort,
    input  logic               ovr_clr,
    input  logic               pos_set,
    input  logic signed [31:0] pos_in,
    output logic               step_o,
    output logic               dir_o,
    output logic               busy,
    output logic               overrun,
    output logic signed [31:0] pos
);

    typedef enum logic [1:0] {IDLE, DSET, HIGH, LOW} state_t;

    // Counters load N-1 and run down to zero, so a phase lasts exactly N enabled cycles.
    localparam logic [15:0] CNT_HIGH = 16'(STEP_HIGH - 1);
    localparam logic [15:0] CNT_LOW  = 16'(STEP_LOW - 1);
    localparam logic [15:0] CNT_DSET = 16'(DIR_SETUP - 1);

    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic               dir_req_q, dir_req_d;
    logic               step_q, step_d;
    logic               pend_vld_q, pend_vld_d;
    logic               pend_dir_q, pend_dir_d;
    logic               busy_q, busy_d;
    logic               ovr_q, ovr_d;
    logic signed [31:0] pos_q, pos_d;

    logic pls_vld;
    logic cnt_done;
    logic launch_vld;
    logic launch_dir;
    logic pls_used;
    logic enter_high;
    logic hi_dir;
    logic ovr_set;

    // Next-state: FSM sequencing, pulse launch (from idle, pending pop or a last-LOW-cycle pls), pending, pos, overrun.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        dir_req_d  = dir_req_q;
        step_d     = step_q;
        pend_vld_d = pend_vld_q;
        pend_dir_d = pend_dir_q;
        pos_d      = pos_q;
        launch_vld = 1'b0;
        launch_dir = dir;
        pls_used   = 1'b0;
        enter_high = 1'b0;
        ovr_set    = 1'b0;
        // A pls coincident with abort is discarded outright.
        pls_vld    = pls & ~abort;
        cnt_done   = (cnt_q == 16'd0);

        case (state_q)
            IDLE: begin
                if (pls_vld) begin
                    launch_vld = 1'b1;
                    launch_dir = dir;
                    pls_used   = 1'b1;
                end
            end
            DSET: begin
                if (abort) begin
                    // DIR has already moved and stays; no step is issued.
                    state_d = IDLE;
                end else if (cnt_done) begin
                    enter_high = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            HIGH: begin
                if (cnt_done) begin
                    state_d = LOW;
                    step_d  = 1'b0;
                    cnt_d   = CNT_LOW;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            LOW: begin
                if (cnt_done) begin
                    // Back-to-back chaining: no idle cycle between the LOW tail and the next launch.
                    if (pend_vld_q && !abort) begin
                        launch_vld = 1'b1;
                        launch_dir = pend_dir_q;
                        pend_vld_d = 1'b0;
                    end else if (!pend_vld_q && pls_vld) begin
                        launch_vld = 1'b1;
                        launch_dir = dir;
                        pls_used   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Launch: go straight to HIGH if DIR already matches, else move DIR and wait out the setup time.
        if (launch_vld) begin
            dir_req_d = launch_dir;
            if (launch_dir == dir_q) begin
                enter_high = 1'b1;
            end else begin
                dir_d   = launch_dir;
                state_d = DSET;
                cnt_d   = CNT_DSET;
            end
        end

        hi_dir = launch_vld ? launch_dir : dir_req_q;
        if (enter_high) begin
            state_d = HIGH;
            step_d  = 1'b1;
            cnt_d   = CNT_HIGH;
        end

        // Pending slot: abort empties it; an unconsumed pls fills it or, if full, is dropped as an overrun.
        if (abort) begin
            pend_vld_d = 1'b0;
        end else if (pls_vld && !pls_used) begin
            if (pend_vld_q) begin
                ovr_set = 1'b1;
            end else begin
                pend_vld_d = 1'b1;
                pend_dir_d = dir;
            end
        end

        // A position load wins over the step count on the same cycle.
        if (pos_set) begin
            pos_d = pos_in;
        end else if (enter_high) begin
            pos_d = hi_dir ? (pos_q + 32'sd1) : (pos_q - 32'sd1);
        end

        // A new overrun beats a simultaneous clear.
        ovr_d  = ovr_set | (ovr_q & ~ovr_clr);
        busy_d = (state_d != IDLE) | pend_vld_d;
    end

    // State registers: synchronous reset regardless of clk_ena, otherwise advance only on enabled cycles.
    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            state_q    <= IDLE;
            cnt_q      <= 16'd0;
            dir_q      <= 1'b0;
            dir_req_q  <= 1'b0;
            step_q     <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_dir_q <= 1'b0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
            pos_q      <= 32'sd0;
        end else if (clk_ena) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            dir_req_q  <= dir_req_d;
            step_q     <= step_d;
            pend_vld_q <= pend_vld_d;
            pend_dir_q <= pend_dir_d;
            busy_q     <= busy_d;
            ovr_q      <= ovr_d;
            pos_q      <= pos_d;
        end
    end

    assign step_o  = step_q ^ INV_STEP;
    assign dir_o   = dir_q ^ INV_DIR;
    assign busy    = busy_q;
    assign overrun = ovr_q;
    assign pos     = pos_q;

endmodule
